// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the IF/EXE SRAM port arbiter: owners, lock states,
// access sizes and the request payload bundle.
package sram_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        LOCK_IDLE   = 2'd0,
        LOCK_HOLD_I = 2'd1,
        LOCK_HOLD_D = 2'd2
    } lock_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic mem_cmd_t pick_cmd(input logic owner, input mem_cmd_t inst_cmd,
                                          input mem_cmd_t data_cmd);
        return (owner == OWN_DATA) ? data_cmd : inst_cmd;
    endfunction

endpackage

// File: rtl/sram_arb_owner_fifo.sv
// In-order record of which requester owns each accepted memory transaction.
// One bit per entry; DEPTH must be a power of two so the pointers wrap freely.
module sram_arb_owner_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_owner,
    input  logic          pop,
    output logic          head_owner,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_owner = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = AW'(wr_ptr_q + 1'b1);
        end
        if (do_pop) begin
            rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one split-transaction SRAM port between the IF fetch and EXE data requesters.
// SRAM_ARB_RR_EN: round-robin tie-break instead of data priority with a starvation guard.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    lock_e       lock_q, lock_d;
    logic        sel_valid, sel_owner, tie_data;
    logic        accept, resp_fire, err_set;
    logic        fifo_full, fifo_empty, head_owner;
    logic [CW-1:0] fifo_count;
    logic        arb_err_q, arb_err_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    mem_cmd_t    inst_cmd, data_cmd, mem_cmd;

    assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    assign tie_data     = (last_grant_q == OWN_INST);
    assign last_grant_d = accept ? ~last_grant_q : last_grant_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_grant_q <= OWN_INST;
        else         last_grant_q <= last_grant_d;
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign tie_data = (starve_q != STARVE_MAX);

    // Counts data wins that happened while a fetch was left waiting.
    always_comb begin
        starve_d = starve_q;
        if (!inst_req || (accept && sel_owner == OWN_INST)) begin
            starve_d = '0;
        end else if (accept && sel_owner == OWN_DATA && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`endif

    // Lock state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lock_q <= LOCK_IDLE;
        else         lock_q <= lock_d;
    end

    // A hold already owns a reserved slot, so only IDLE consults the FIFO.
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = OWN_DATA;
        unique case (lock_q)
            LOCK_HOLD_I: begin
                sel_valid = 1'b1;
                sel_owner = OWN_INST;
            end
            LOCK_HOLD_D: begin
                sel_valid = 1'b1;
                sel_owner = OWN_DATA;
            end
            default: begin
                if (!fifo_full) begin
                    if (inst_req && data_req) begin
                        sel_valid = 1'b1;
                        sel_owner = tie_data ? OWN_DATA : OWN_INST;
                    end else if (inst_req) begin
                        sel_valid = 1'b1;
                        sel_owner = OWN_INST;
                    end else if (data_req) begin
                        sel_valid = 1'b1;
                        sel_owner = OWN_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        lock_d = lock_q;
        if (accept) begin
            lock_d = LOCK_IDLE;
        end else if (lock_q == LOCK_IDLE && mem_req) begin
            lock_d = (sel_owner == OWN_DATA) ? LOCK_HOLD_D : LOCK_HOLD_I;
        end
    end

    // Outputs; gated by resetn so the port goes quiet the moment reset asserts.
    always_comb begin
        mem_req = resetn & sel_valid;
        mem_cmd = mem_req ? pick_cmd(sel_owner, inst_cmd, data_cmd) : '0;
        accept  = mem_req & mem_addr_ok;
        resp_fire = resetn & mem_data_ok & ~fifo_empty;
        err_set   = resetn & mem_data_ok & (fifo_count == '0);
    end

    assign mem_wr    = mem_cmd.wr;
    assign mem_size  = mem_cmd.size;
    assign mem_addr  = mem_cmd.addr;
    assign mem_wdata = mem_cmd.wdata;

    assign inst_addr_ok = accept & (sel_owner == OWN_INST);
    assign data_addr_ok = accept & (sel_owner == OWN_DATA);
    assign inst_data_ok = resp_fire & (head_owner == OWN_INST);
    assign data_data_ok = resp_fire & (head_owner == OWN_DATA);

    always_comb begin
        inst_rdata_d = inst_data_ok ? mem_rdata : inst_rdata_q;
        data_rdata_d = data_data_ok ? mem_rdata : data_rdata_q;
        arb_err_d    = arb_err_q | err_set;
    end

    assign inst_rdata = inst_rdata_d;
    assign data_rdata = data_rdata_d;
    assign arb_err    = arb_err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            arb_err_q    <= arb_err_d;
        end
    end

    sram_arb_owner_fifo #(.DEPTH(MAX_OUTST)) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_owner (sel_owner),
        .pop        (resp_fire),
        .head_owner (head_owner),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage instruction requester and the EXE-stage data requester.
- Both requesters use the req / addr_ok / data_ok split-transaction handshake.
- Arbitrates the address phase, holds a grant stable until the memory accepts it, and records the owner of every accepted request in order.
- Routes each data_ok/rdata back to the owning requester; sits between the pipeline stages and the memory bridge.

Parameters:
- MAX_OUTST, 2, max accepted-but-unanswered transactions (owner FIFO depth, power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive data grants while inst waits before inst is forced through (1..15)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active low
- inst_req  in  1  fetch request
- inst_wr  in  1  always 0 from IF; forwarded as is
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  fetch address
- inst_wdata  in  32  unused by IF; forwarded
- inst_addr_ok  out  1  inst address phase accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst response data
- data_req  in  1  load/store request
- data_wr  in  1  1=store
- data_size  in  2  access size
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data address phase accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data response data
- mem_req  out  1  request to memory
- mem_wr  out  1  write flag
- mem_size  out  2  size
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_addr_ok  in  1  memory accepted address phase
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory response data
- arb_err  out  1  sticky: mem_data_ok seen with owner FIFO empty

Behaviour:
- Reset (resetn=0, async): lock idle, owner FIFO empty, starve counter 0, arb_err 0. All *_ok outputs, mem_req and mem_wr are 0; mem_addr, mem_size and mem_wdata are 0.
- Lock states:
  - IDLE: no request is presented to memory.
  - HOLD_I: the inst request is presented; selected owner is latched.
  - HOLD_D: the data request is presented; selected owner is latched.
- Selection from IDLE (combinational, same cycle): needs FIFO not full. Only one req high → select it. Both high → data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
- The selected requester's wr/size/addr/wdata drive mem_* combinationally, with mem_req = 1.
- If mem_addr_ok is not returned in that cycle, the lock moves to HOLD_I or HOLD_D. The selection is frozen until mem_addr_ok, even if the other requester asserts req.
- Requesters keep req and payload stable until addr_ok; the arbiter does not check this.
- Acceptance (mem_req & mem_addr_ok):
  - Pulse the owner's *_addr_ok for 1 cycle (combinational passthrough, zero latency).
  - Push the owner bit (0=inst, 1=data) into the FIFO.
  - Return the lock to IDLE. A new selection can be made the next cycle.
  - Back-to-back acceptances are allowed, one per cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each data acceptance while inst_req=1.
  - Clears on inst acceptance or when inst_req=0.
- FIFO full: mem_req is held at 0 in IDLE. A HOLD state already presenting stays presenting, because the slot count is reserved at selection.
- Slot accounting: count + (lock≠IDLE) ≤ MAX_OUTST at all times.
- Response (mem_data_ok):
  - Pop the head of the FIFO.
  - Assert the owner's *_data_ok for 1 cycle, combinational.
  - Route mem_rdata to that requester's rdata. The other rdata holds its last value.
  - Responses are delivered in acceptance order.
- Same-cycle push and pop: both apply, count is unchanged. When full, a pop in the same cycle frees a slot for the next cycle's selection, not the current one.
- mem_data_ok with FIFO empty: ignored, arb_err set to 1 until reset.
- Reset mid-transaction clears all state. The memory side is reset from the same resetn.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: the both-request tie is broken round-robin. A last_grant register flips on each acceptance; the starve counter and STARVE_LIMIT are unused, and the counter is tied to 0.
- Undefined: data-priority with starvation guard as described above.

Decomposition:
- Shared package/header: owner encodings OWN_INST=1'b0, OWN_DATA=1'b1; lock state encodings IDLE/HOLD_I/HOLD_D; size encodings.
- One sub-module: sram_arb_owner_fifo (1-bit wide, MAX_OUTST deep; push/pop/full/empty/count; async active-low reset).

Test Plan:
- Inst only, addr 0xBFC00000, mem_addr_ok same cycle, data_ok 2 cycles later with rdata 0x3C010001 → inst_addr_ok pulse at cycle 0, inst_data_ok with rdata 0x3C010001 at cycle 2, data_* silent.
- Both req in one cycle, mem_addr_ok delayed 3 cycles → data selected, mem_addr stays = data_addr for all 3 cycles despite inst_req, then data_addr_ok pulses; inst accepted the next cycle.
- Two accepts (data then inst) with responses 0xAAAA0000 then 0x5555FFFF → data_rdata=0xAAAA0000 first, inst_rdata=0x5555FFFF second; ordering is preserved.
- MAX_OUTST=2, no data_ok returned → third request sees mem_req=0; a data_ok pulse in cycle N allows mem_req=1 in cycle N+1.
- Both requesters continuously requesting, STARVE_LIMIT=4 → pattern is 4 data grants then 1 inst grant, repeating. With SRAM_ARB_RR_EN, grants alternate D,I,D,I.
- mem_data_ok with FIFO empty → no *_data_ok pulse, arb_err=1. resetn low for 1 cycle mid-HOLD → mem_req=0 immediately, arb_err=0.
